// File: rtl/alu_exec_unit_if.sv
// Operand/result bundle for the RV32I/M execute unit.
// master drives the decoded instruction fields and operands; slave returns registered results.
interface alu_exec_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            aluOp;
    logic [6:0]            funct7;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] bus_a;
    logic [DATA_WIDTH-1:0] bus_b;
    logic [DATA_WIDTH-1:0] out;
    logic                  overflow;
    logic                  Z;
    logic                  error;

    modport master (
        output aluOp, funct7, funct3, bus_a, bus_b,
        input  out, overflow, Z, error
    );

    modport slave (
        input  aluOp, funct7, funct3, bus_a, bus_b,
        output out, overflow, Z, error
    );
endinterface

// File: rtl/alu_exec_unit.sv
// RV32I/RV32M execute unit: combinational decode and datapath, one result register stage.
// Define ALU_RV32M_EN to build the multiplier/divider; otherwise funct7=0x01 decodes as illegal.
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32
) (
    input logic            clk,
    input logic            rstN,
    alu_exec_unit_if.slave alu
);

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILLEGAL
    } op_e;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_MEXT = 7'h01;

    op_e                   op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] result;
    logic                  ov_c;
    logic                  illegal;

    logic [DATA_WIDTH-1:0] out_q;
    logic                  overflow_q;
    logic                  z_q;
    logic                  error_q;

    assign a     = alu.bus_a;
    assign b     = alu.bus_b;
    assign shamt = alu.bus_b[4:0];
    assign sum   = a + b;
    assign diff  = a - b;

    function automatic op_e base_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return OP_ADD;
            3'd1:    return OP_SLL;
            3'd2:    return OP_SLT;
            3'd3:    return OP_SLTU;
            3'd4:    return OP_XOR;
            3'd5:    return OP_SRL;
            3'd6:    return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

`ifdef ALU_RV32M_EN
    function automatic op_e mext_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return OP_MUL;
            3'd1:    return OP_MULH;
            3'd2:    return OP_MULHSU;
            3'd3:    return OP_MULHU;
            3'd4:    return OP_DIV;
            3'd5:    return OP_DIVU;
            3'd6:    return OP_REM;
            default: return OP_REMU;
        endcase
    endfunction
`endif

    always_comb begin
        op = OP_ILLEGAL;
        case (alu.aluOp)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case (alu.funct7)
                    F7_BASE: op = base_op(alu.funct3);
                    F7_ALT: begin
                        if (alu.funct3 == 3'd0)      op = OP_SUB;
                        else if (alu.funct3 == 3'd5) op = OP_SRA;
                    end
`ifdef ALU_RV32M_EN
                    F7_MEXT: op = mext_op(alu.funct3);
`endif
                    default: op = OP_ILLEGAL;
                endcase
            end
            default: begin
                case (alu.funct3)
                    3'd0: op = OP_ADD;
                    3'd1: if (alu.funct7 == F7_BASE) op = OP_SLL;
                    3'd5: begin
                        if (alu.funct7 == F7_BASE)     op = OP_SRL;
                        else if (alu.funct7 == F7_ALT) op = OP_SRA;
                    end
                    default: op = base_op(alu.funct3);
                endcase
            end
        endcase
    end

`ifdef ALU_RV32M_EN
    // One 64-bit multiplier serves all variants: operands are sign- or zero-extended
    // per op and the product is taken modulo 2^64.
    logic                    a_signed_mul;
    logic                    b_signed_mul;
    logic [2*DATA_WIDTH-1:0] mul_a;
    logic [2*DATA_WIDTH-1:0] mul_b;
    logic [2*DATA_WIDTH-1:0] prod;

    assign a_signed_mul = (op == OP_MULH) || (op == OP_MULHSU);
    assign b_signed_mul = (op == OP_MULH);
    assign mul_a = {{DATA_WIDTH{a_signed_mul & a[DATA_WIDTH-1]}}, a};
    assign mul_b = {{DATA_WIDTH{b_signed_mul & b[DATA_WIDTH-1]}}, b};
    assign prod  = mul_a * mul_b;

    // Magnitude divide with sign fix-up; MIN/-1 falls out naturally as MIN rem 0.
    logic                  div_signed;
    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic [DATA_WIDTH-1:0] divisor;
    logic [DATA_WIDTH-1:0] q_mag;
    logic [DATA_WIDTH-1:0] r_mag;
    logic [DATA_WIDTH-1:0] quot;
    logic [DATA_WIDTH-1:0] rem;
    logic                  b_zero;

    assign div_signed = (op == OP_DIV) || (op == OP_REM);
    assign a_neg   = div_signed & a[DATA_WIDTH-1];
    assign b_neg   = div_signed & b[DATA_WIDTH-1];
    assign a_mag   = a_neg ? ('0 - a) : a;
    assign b_mag   = b_neg ? ('0 - b) : b;
    assign b_zero  = (b == '0);
    assign divisor = b_zero ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : b_mag;
    assign q_mag   = a_mag / divisor;
    assign r_mag   = a_mag % divisor;
    assign quot    = b_zero ? '1 : ((a_neg ^ b_neg) ? ('0 - q_mag) : q_mag);
    assign rem     = b_zero ? a  : (a_neg ? ('0 - r_mag) : r_mag);
`endif

    always_comb begin
        result = '0;
        ov_c   = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum;
                ov_c   = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                         (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
            end
            OP_SUB: begin
                result = diff;
                ov_c   = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                         (diff[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
            end
            OP_SLL:  result = a << shamt;
            OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> shamt);
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
`ifdef ALU_RV32M_EN
            OP_MUL:    result = prod[DATA_WIDTH-1:0];
            OP_MULH:   result = prod[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_MULHSU: result = prod[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_MULHU:  result = prod[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIV:    result = quot;
            OP_DIVU:   result = quot;
            OP_REM:    result = rem;
            OP_REMU:   result = rem;
`endif
            default: result = '0;
        endcase
    end

    assign illegal = (op == OP_ILLEGAL);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            out_q      <= '0;
            overflow_q <= 1'b0;
            z_q        <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            out_q      <= illegal ? '0 : result;
            overflow_q <= !illegal && ov_c;
            z_q        <= !illegal && (result == '0);
            error_q    <= illegal;
        end
    end

    assign alu.out      = out_q;
    assign alu.overflow = overflow_q;
    assign alu.Z        = z_q;
    assign alu.error    = error_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors push expectations, monitors pop and compare.
// M-extension expectations follow ALU_RV32M_EN, matching the build of the design.
module tb_alu_exec_unit;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    alu_exec_unit_if #(.DATA_WIDTH(32)) alu_if ();

    alu_exec_unit #(.DATA_WIDTH(32)) dut (
        .clk  (clk),
        .rstN (rstN),
        .alu  (alu_if.slave)
    );

    typedef struct {
        string       name;
        logic [31:0] out;
        logic        ov;
        logic        z;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic        issue = 1'b0;
    event        rst_chk;

    localparam logic [31:0] A = 32'hFFFFF6A0;
    localparam logic [31:0] B = 32'hFFFFFFF4;

    function automatic void compare(input exp_t e);
        n_cmp++;
        if (alu_if.out !== e.out || alu_if.overflow !== e.ov ||
            alu_if.Z !== e.z || alu_if.error !== e.err) begin
            n_bad++;
            $display("FAIL %s: got out=%h ov=%b Z=%b err=%b, expected out=%h ov=%b Z=%b err=%b",
                     e.name, alu_if.out, alu_if.overflow, alu_if.Z, alu_if.error,
                     e.out, e.ov, e.z, e.err);
        end
    endfunction

    function automatic void pop_and_compare(input string where);
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no expectation queued, expected one", where);
        end else begin
            compare(sb.pop_front());
        end
    endfunction

    always @(posedge clk) begin
        if (rstN && issue) begin
            #1;
            pop_and_compare("op_monitor");
        end
    end

    always @(rst_chk) pop_and_compare("reset_monitor");

    task automatic op(input string name, input logic [1:0] aop, input logic [6:0] f7,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e_out, input logic e_ov, input logic e_z,
                      input logic e_err);
        exp_t e;
        @(negedge clk);
        alu_if.aluOp  = aop;
        alu_if.funct7 = f7;
        alu_if.funct3 = f3;
        alu_if.bus_a  = a;
        alu_if.bus_b  = b;
        issue         = 1'b1;
        e.name = name; e.out = e_out; e.ov = e_ov; e.z = e_z; e.err = e_err;
        sb.push_back(e);
    endtask

    task automatic expect_reset(input string name);
        exp_t e;
        e.name = name; e.out = '0; e.ov = 1'b0; e.z = 1'b0; e.err = 1'b0;
        sb.push_back(e);
        -> rst_chk;
    endtask

    task automatic illegal_op(input string name, input logic [1:0] aop,
                              input logic [6:0] f7, input logic [2:0] f3);
        op(name, aop, f7, f3, A, B, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        alu_if.aluOp  = 2'b00;
        alu_if.funct7 = 7'h00;
        alu_if.funct3 = 3'd0;
        alu_if.bus_a  = 32'h0000_0010;
        alu_if.bus_b  = 32'h0000_0020;
        #12;
        expect_reset("reset_initial");
        @(negedge clk);
        rstN = 1'b1;

        // Reset asserted while an operation is in flight.
        op("pre_reset_add", 2'b00, 7'h00, 3'd0, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        issue = 1'b0;
        rstN  = 1'b0;
        #1;
        expect_reset("reset_async");
        @(posedge clk);
        #2;
        expect_reset("reset_held");
        @(negedge clk);
        rstN = 1'b1;

        op("add_class", 2'b00, 7'h00, 3'd0, 32'd5, 32'd7, 32'h0000000C, 1'b0, 1'b0, 1'b0);

        op("r_add",  2'b10, 7'h00, 3'd0, A, B, 32'hFFFFF694, 1'b0, 1'b0, 1'b0);
        op("r_sll",  2'b10, 7'h00, 3'd1, A, B, 32'h6A000000, 1'b0, 1'b0, 1'b0);
        op("r_slt",  2'b10, 7'h00, 3'd2, A, B, 32'h00000001, 1'b0, 1'b0, 1'b0);
        op("r_sltu", 2'b10, 7'h00, 3'd3, A, B, 32'h00000001, 1'b0, 1'b0, 1'b0);
        op("r_xor",  2'b10, 7'h00, 3'd4, A, B, 32'h00000954, 1'b0, 1'b0, 1'b0);
        op("r_srl",  2'b10, 7'h00, 3'd5, A, B, 32'h00000FFF, 1'b0, 1'b0, 1'b0);
        op("r_or",   2'b10, 7'h00, 3'd6, A, B, 32'hFFFFFFF4, 1'b0, 1'b0, 1'b0);
        op("r_and",  2'b10, 7'h00, 3'd7, A, B, 32'hFFFFF6A0, 1'b0, 1'b0, 1'b0);
        op("r_sub",  2'b10, 7'h20, 3'd0, A, B, 32'hFFFFF6AC, 1'b0, 1'b0, 1'b0);
        op("r_sra",  2'b10, 7'h20, 3'd5, A, B, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

`ifdef ALU_RV32M_EN
        op("m_mul",    2'b10, 7'h01, 3'd0, A, B, 32'h00007080, 1'b0, 1'b0, 1'b0);
        op("m_mulh",   2'b10, 7'h01, 3'd1, A, B, 32'h00000000, 1'b0, 1'b1, 1'b0);
        op("m_mulhsu", 2'b10, 7'h01, 3'd2, A, B, 32'hFFFFF6A0, 1'b0, 1'b0, 1'b0);
        op("m_mulhu",  2'b10, 7'h01, 3'd3, A, B, 32'hFFFFF694, 1'b0, 1'b0, 1'b0);
        op("m_div",    2'b10, 7'h01, 3'd4, A, B, 32'h000000C8, 1'b0, 1'b0, 1'b0);
        op("m_divu",   2'b10, 7'h01, 3'd5, A, B, 32'h00000000, 1'b0, 1'b1, 1'b0);
        op("m_rem",    2'b10, 7'h01, 3'd6, A, B, 32'h00000000, 1'b0, 1'b1, 1'b0);
        op("m_remu",   2'b10, 7'h01, 3'd7, A, B, 32'hFFFFF6A0, 1'b0, 1'b0, 1'b0);
        op("div_by_zero", 2'b10, 7'h01, 3'd4, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        op("rem_by_zero", 2'b10, 7'h01, 3'd6, 32'd7, 32'd0, 32'h00000007, 1'b0, 1'b0, 1'b0);
        op("div_ovf", 2'b10, 7'h01, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b0);
        op("rem_ovf", 2'b10, 7'h01, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0);
        op("div_neg", 2'b10, 7'h01, 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
        op("rem_neg", 2'b10, 7'h01, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
`else
        for (int i = 0; i < 8; i++) illegal_op("m_disabled", 2'b10, 7'h01, 3'(i));
`endif

        op("add_ovf",  2'b00, 7'h00, 3'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 1'b0, 1'b0);
        op("sub_zero", 2'b01, 7'h00, 3'd0, 32'd5, 32'd5, 32'h00000000, 1'b0, 1'b1, 1'b0);
        op("sub_ovf",  2'b01, 7'h00, 3'd0, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);

        op("i_add_f7_ignored", 2'b11, 7'h20, 3'd0, 32'd3, 32'd4, 32'h00000007, 1'b0, 1'b0, 1'b0);
        op("i_sra", 2'b11, 7'h20, 3'd5, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0, 1'b0);
        op("i_srl", 2'b11, 7'h00, 3'd5, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1'b0, 1'b0);
        op("i_xor_f7_ignored", 2'b11, 7'h7F, 3'd4, A, B, 32'h00000954, 1'b0, 1'b0, 1'b0);

        illegal_op("ill_r_f7_20_f3_4", 2'b10, 7'h20, 3'd4);
        illegal_op("ill_r_f7_02",      2'b10, 7'h02, 3'd0);
        illegal_op("ill_i_f3_1_f7_20", 2'b11, 7'h20, 3'd1);
        illegal_op("ill_i_f3_5_f7_01", 2'b11, 7'h01, 3'd5);

        op("after_illegal", 2'b00, 7'h00, 3'd0, 32'd1, 32'd2, 32'h00000003, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        issue = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
